serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Serial-to-parallel frame receiver that sits directly upstream of the datapath's parallel word consumers. It takes the same single-bit serial line that feeds the team's shift-register stage and recovers framed words from it: start bit, DATA_WIDTH data bits LSB-first, optional even parity, stop bit. Each completed word is presented on a one-entry valid/ready output register, with parity, framing and overrun status.

## Interface
- DATA_WIDTH, 4, data bits per frame; must be >= 2.
- PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit.

- i_clk  input  1  single clock; all logic rises on posedge.
- i_reset_n_async  input  1  asynchronous, active-low reset.
- i_en  input  1  bit strobe: i_x is sampled only in cycles where i_en=1.
- i_x  input  1  serial line; idles high.
- o_data  output  DATA_WIDTH  received word; valid only while o_valid=1.
- o_valid  output  1  word available in output register.
- i_ready  input  1  consumer accepts; transfer when o_valid && i_ready.
- o_parity_err  output  1  qualifies o_data: parity mismatch on this word; 0 when PARITY_EN=0.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled 0, frame dropped.
- o_overrun  output  1  one-cycle pulse: good frame dropped because output register full.
- o_busy  output  1  1 whenever FSM is not IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. State, shift register and bit counter change only on i_en=1 cycles; i_en=0 holds everything except output handshake.
- IDLE: i_en && i_x==0 -> DATA, bit counter cleared. i_x==1 stays IDLE.
- DATA: each i_en shifts right, {i_x, sr[DATA_WIDTH-1:1]}, so the first data bit ends in bit 0; counter increments. After the DATA_WIDTH-th bit -> PARITY if PARITY_EN, else STOP. Counter width $clog2(DATA_WIDTH).
- PARITY: on i_en, parity error = ^sr ^ i_x (nonzero means error). Latched for the frame -> STOP.
- STOP: on i_en -> IDLE always. i_x==1: frame good, deliver. i_x==0: frame dropped, o_frame_err pulses, output register untouched.
- Deliver: if output register empty, or draining in the same cycle (o_valid && i_ready), load o_data and o_parity_err and set o_valid. Otherwise drop the frame, pulse o_overrun, and keep the held word unchanged.
- A word with a parity error is still delivered; o_parity_err flags it.
- o_valid clears on o_valid && i_ready unless a new word loads in the same cycle.
- A start bit may arrive on the i_en immediately after the stop bit; back-to-back frames are supported.

## Timing
- Reset (async assert): FSM=IDLE; shift register, counter, o_data=0; o_valid, o_parity_err, o_frame_err, o_overrun, o_busy=0. Reset mid-frame abandons the frame and delivers nothing.
- o_busy=1 in the cycle after the start-bit i_en.
- o_valid rises, and o_frame_err or o_overrun pulse, in the cycle after the i_en cycle that samples the stop bit.
- Minimum frame = 1 + DATA_WIDTH + PARITY_EN + 1 i_en cycles.
- o_data and o_parity_err are stable while o_valid=1 and i_ready=0.
- All outputs are registered; no combinational path from i_x or i_ready to outputs.

## Test plan
- DATA_WIDTH=4, PARITY_EN=1, i_en=1 constantly, i_ready=1. Send i_x = 0, 0,1,0,1, 0, 1. Required: o_data=4'hA, o_valid=1 for one cycle, o_parity_err=0, o_busy=0 afterwards.
- Same frame with parity bit 1. Required: o_data=4'hA, o_parity_err=1, o_valid=1.
- Send 4'h3 with stop bit 0. Required: o_frame_err pulses one cycle, o_valid stays 0, FSM returns to IDLE, and the next good frame 4'h5 is received normally.
- i_ready=0; send 4'h1 then 4'h2 back-to-back. Required: o_data=4'h1 held, o_overrun pulses after the second stop bit. Then i_ready=1: 4'h1 transfers and o_valid drops.
- Hold a word with o_valid=1, i_ready=0. Raise i_ready in the exact cycle the next frame (4'hC) completes. Required: no o_overrun, and the following cycle o_data=4'hC with o_valid=1.
- Gaps of i_en=0 (random, up to 5 cycles) between the bits of 4'h9: frame still received correctly. Assert i_reset_n_async mid-frame: all outputs go to 0 immediately and no word is delivered.

Source files
------------

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//
// Recovers framed words from a single-bit serial line that idles high.
// Frame: start bit (0), DATA_WIDTH data bits LSB-first, optional even-parity
// bit, stop bit (1). The line is sampled only in cycles where i_en=1.
// Each good frame is placed in a one-entry valid/ready output register.
//
// Parameters
//   DATA_WIDTH  data bits per frame (>= 2)
//   PARITY_EN   1 = even-parity bit follows the data, 0 = no parity bit
//
// Ports
//   i_clk            clock, all logic on posedge
//   i_reset_n_async  asynchronous active-low reset
//   i_en             bit strobe; i_x is sampled only when high
//   i_x              serial line
//   o_data           received word (valid while o_valid=1)
//   o_valid          output register holds a word
//   i_ready          consumer accepts; transfer on o_valid && i_ready
//   o_parity_err     parity mismatch on the held word
//   o_frame_err      one-cycle pulse: stop bit was 0, frame dropped
//   o_overrun        one-cycle pulse: good frame dropped, register full
//   o_busy           receiver is inside a frame
// ---------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DATA_WIDTH = 4,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n_async,
  input  logic                  i_en,
  input  logic                  i_x,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  frame_perr_q, frame_perr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  take;

  always_ff @(posedge i_clk or negedge i_reset_n_async) begin
    if (!i_reset_n_async) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      frame_perr_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      frame_perr_q <= frame_perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    frame_perr_d = frame_perr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    perr_d       = perr_q;
    ferr_d       = 1'b0;
    ovr_d        = 1'b0;

    take = valid_q && i_ready;
    if (take) begin
      valid_d = 1'b0;
    end

    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (!i_x) begin
            state_d      = DATA;
            cnt_d        = '0;
            frame_perr_d = 1'b0;
          end
        end
        DATA: begin
          // Shift right so the first (LSB) data bit ends up in bit 0.
          sr_d  = {i_x, sr_q[DATA_WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          // Even parity: XOR of data and parity bit must be zero.
          frame_perr_d = (^sr_q) ^ i_x;
          state_d      = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (i_x) begin
            // A word draining this very cycle frees the slot for the new one.
            if (!valid_q || take) begin
              data_d  = sr_q;
              perr_d  = frame_perr_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;
  // Decoded purely from the state register, so still free of input paths.
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  logic       i_clk = 1'b0;
  logic       i_reset_n_async;
  logic       i_en;
  logic       i_x;
  logic       i_ready;
  logic [3:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;

  serial_frame_rx #(.DATA_WIDTH(4), .PARITY_EN(1'b1)) dut (
    .i_clk           (i_clk),
    .i_reset_n_async (i_reset_n_async),
    .i_en            (i_en),
    .i_x             (i_x),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_parity_err    (o_parity_err),
    .o_frame_err     (o_frame_err),
    .o_overrun       (o_overrun),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One serial bit, optionally preceded by up to max_gap idle strobes with
  // a random line value that must be ignored.
  task automatic send_bit(input logic b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      @(negedge i_clk);
      i_en = 1'b0;
      i_x  = 1'($urandom_range(0, 1));
    end
    @(negedge i_clk);
    i_en = 1'b1;
    i_x  = b;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par, input logic stp,
                            input logic rdy_at_stop, input int max_gap);
    send_bit(1'b0, max_gap);
    for (int k = 0; k < 4; k++) send_bit(d[k], max_gap);
    send_bit(par, max_gap);
    send_bit(stp, max_gap);
    if (rdy_at_stop) i_ready = 1'b1;
  endtask

  // Moves to the negedge after the stop-bit sample; outputs now show the result.
  task automatic end_frame();
    @(negedge i_clk);
    i_en = 1'b0;
    i_x  = 1'b1;
  endtask

  initial begin
    i_reset_n_async = 1'b0;
    i_en    = 1'b0;
    i_x     = 1'b1;
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    check_val("rst_valid", o_valid, 0);
    check_val("rst_data", o_data, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_flags", {o_parity_err, o_frame_err, o_overrun}, 0);
    i_reset_n_async = 1'b1;
    @(negedge i_clk);

    // Good frame 0xA, correct parity
    send_frame(4'hA, 1'b0, 1'b1, 1'b0, 0);
    end_frame();
    check_val("A_valid", o_valid, 1);
    check_val("A_data", o_data, 4'hA);
    check_val("A_perr", o_parity_err, 0);
    check_val("A_busy", o_busy, 0);
    @(negedge i_clk);
    check_val("A_valid_1cyc", o_valid, 0);

    // Same word, wrong parity: still delivered, flagged
    send_frame(4'hA, 1'b1, 1'b1, 1'b0, 0);
    end_frame();
    check_val("Ap_valid", o_valid, 1);
    check_val("Ap_data", o_data, 4'hA);
    check_val("Ap_perr", o_parity_err, 1);
    @(negedge i_clk);

    // Framing error on 0x3, then 0x5 received normally
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 0);
    end_frame();
    check_val("F_ferr", o_frame_err, 1);
    check_val("F_valid", o_valid, 0);
    check_val("F_busy", o_busy, 0);
    @(negedge i_clk);
    check_val("F_ferr_pulse", o_frame_err, 0);
    send_frame(4'h5, 1'b0, 1'b1, 1'b0, 0);
    end_frame();
    check_val("F5_valid", o_valid, 1);
    check_val("F5_data", o_data, 4'h5);
    @(negedge i_clk);

    // Overrun: 0x1 then 0x2 back-to-back with consumer stalled
    i_ready = 1'b0;
    send_frame(4'h1, 1'b1, 1'b1, 1'b0, 0);
    send_frame(4'h2, 1'b1, 1'b1, 1'b0, 0);
    end_frame();
    check_val("O_ovr", o_overrun, 1);
    check_val("O_data", o_data, 4'h1);
    check_val("O_valid", o_valid, 1);
    @(negedge i_clk);
    check_val("O_ovr_pulse", o_overrun, 0);
    check_val("O_data_hold", o_data, 4'h1);
    i_ready = 1'b1;
    @(negedge i_clk);
    check_val("O_drained", o_valid, 0);

    // Drain and load in the same cycle: held 0x7, then 0xC
    i_ready = 1'b0;
    send_frame(4'h7, 1'b1, 1'b1, 1'b0, 0);
    end_frame();
    check_val("S7_data", o_data, 4'h7);
    send_frame(4'hC, 1'b0, 1'b1, 1'b1, 0);
    end_frame();
    check_val("SC_ovr", o_overrun, 0);
    check_val("SC_valid", o_valid, 1);
    check_val("SC_data", o_data, 4'hC);
    @(negedge i_clk);
    check_val("SC_drained", o_valid, 0);

    // Random enable gaps inside frame 0x9
    send_frame(4'h9, 1'b0, 1'b1, 1'b0, 5);
    end_frame();
    check_val("G_valid", o_valid, 1);
    check_val("G_data", o_data, 4'h9);
    check_val("G_perr", o_parity_err, 0);
    @(negedge i_clk);

    // Reset mid-frame with a word held
    i_ready = 1'b0;
    send_frame(4'h6, 1'b0, 1'b1, 1'b0, 0);
    end_frame();
    check_val("R6_data", o_data, 4'h6);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge i_clk);
    i_en = 1'b0;
    check_val("R_busy_mid", o_busy, 1);
    #2 i_reset_n_async = 1'b0;
    #1;
    check_val("R_valid", o_valid, 0);
    check_val("R_data", o_data, 0);
    check_val("R_busy", o_busy, 0);
    @(negedge i_clk);
    i_reset_n_async = 1'b1;
    i_x = 1'b1;
    i_en = 1'b1;
    repeat (8) @(negedge i_clk);
    check_val("R_no_word", o_valid, 0);
    check_val("R_idle", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
